// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup, EX-resolve and statistics signals of the branch predictor, bundled.
// master = pipeline side (drives PCs and resolved outcomes), slave = predictor.
interface branch_predict_unit_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 32
);
    logic [ADDR_W-1:0] pc_f;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic [STAT_W-1:0] stat_total;
    logic [STAT_W-1:0] stat_miss;

    modport master (
        output pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, stat_total, stat_miss
    );

    modport slave (
        input  pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, stat_total, stat_miss
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: direct-mapped 2-bit BHT + tagged BTB; optional counters under BRANCH_STATS_EN.
// Latency: lookup and resolve are combinational; table updates land on the next posedge.
// Backpressure: none, one lookup and at most one update accepted every cycle.
module branch_predict_unit #(
    parameter int         ADDR_W   = 32,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predict_unit_if.slave bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [1:0]        bht        [DEPTH];
    logic [DEPTH-1:0]  btb_valid;
    logic [TAG_W-1:0]  btb_tag    [DEPTH];
    logic [ADDR_W-1:0] btb_target [DEPTH];

    logic [IDX_W-1:0]  idx_f, idx_u;
    logic [TAG_W-1:0]  tag_f, tag_u;
    logic              hit_f, taken_f;
    logic [ADDR_W-1:0] correct_u;
    logic              unused_pred_taken;

    // The fetch-time direction guess is irrelevant here: only the next-PC decides a flush.
    assign unused_pred_taken = bp.upd_pred_taken;

    always_comb begin
        idx_f          = bp.pc_f[IDX_W+1:2];
        tag_f          = bp.pc_f[ADDR_W-1:IDX_W+2];
        hit_f          = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
        taken_f        = hit_f && bht[idx_f][1];
        bp.pred_taken  = taken_f;
        bp.pred_target = taken_f ? btb_target[idx_f] : bp.pc_f + ADDR_W'(4);
    end

    always_comb begin
        idx_u          = bp.upd_pc[IDX_W+1:2];
        tag_u          = bp.upd_pc[ADDR_W-1:IDX_W+2];
        correct_u      = bp.upd_taken ? bp.upd_target : bp.upd_pc + ADDR_W'(4);
        bp.redirect_pc = correct_u;
        bp.mispredict  = bp.upd_valid && (correct_u != bp.upd_pred_target);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (bp.upd_valid) begin
            if (bp.upd_taken) begin
                btb_valid[idx_u] <= 1'b1;
                if (bht[idx_u] != 2'b11) bht[idx_u] <= bht[idx_u] + 2'd1;
            end else if (bht[idx_u] != 2'b00) begin
                bht[idx_u] <= bht[idx_u] - 2'd1;
            end
        end
    end

    // Tag/target content is only ever trusted behind btb_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (bp.upd_valid && bp.upd_taken) begin
            btb_tag[idx_u]    <= tag_u;
            btb_target[idx_u] <= bp.upd_target;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] total_q, miss_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
            miss_q  <= '0;
        end else begin
            if (bp.upd_valid && (total_q != '1)) total_q <= total_q + STAT_W'(1);
            if (bp.mispredict && (miss_q != '1))  miss_q  <= miss_q + STAT_W'(1);
        end
    end

    assign bp.stat_total = total_q;
    assign bp.stat_miss  = miss_q;
`else
    assign bp.stat_total = '0;
    assign bp.stat_miss  = '0;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed + random bench for branch_predict_unit against an array/arithmetic reference model.
module tb_branch_predict_unit;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    branch_predict_unit_if #(.ADDR_W(32), .STAT_W(32)) bp ();

    branch_predict_unit #(.ADDR_W(32), .IDX_W(6), .CNT_INIT(2'b01), .STAT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp.slave)
    );

    always #5 clk = ~clk;

    // Reference model: entry = (pc / 4) mod 64, tag = pc / 256, counter kept as a plain int 0..3.
    int          m_cnt [64];
    bit          m_val [64];
    logic [31:0] m_tag [64];
    logic [31:0] m_tgt [64];
    longint      m_total, m_miss;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_val[midx(pc)] && (m_tag[midx(pc)] == pc / 256) && (m_cnt[midx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_cnt[i] = 1;
            m_val[i] = 1'b0;
        end
        m_total = 0;
        m_miss  = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs 1ns later, model commits at posedge.
    task automatic cycle(input bit rst_v, input logic [31:0] pcf, input bit uv, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utg, input bit upt, input logic [31:0] uptg);
        logic [31:0] correct;
        bit          mis;
        @(negedge clk);
        reset              = rst_v;
        bp.pc_f            = pcf;
        bp.upd_valid       = uv;
        bp.upd_pc          = upc;
        bp.upd_taken       = ut;
        bp.upd_target      = utg;
        bp.upd_pred_taken  = upt;
        bp.upd_pred_target = uptg;
        if (!rst_v) model_reset();
        #1;
        correct = ut ? utg : upc + 32'd4;
        mis     = uv && (correct != uptg);
        chk("pred_taken", 64'(bp.pred_taken), 64'(m_pred_taken(pcf)));
        chk("pred_target", 64'(bp.pred_target), 64'(m_pred_target(pcf)));
        chk("mispredict", 64'(bp.mispredict), 64'(mis));
        if (uv) chk("redirect_pc", 64'(bp.redirect_pc), 64'(correct));
`ifdef BRANCH_STATS_EN
        chk("stat_total", 64'(bp.stat_total), 64'(m_total));
        chk("stat_miss", 64'(bp.stat_miss), 64'(m_miss));
`else
        chk("stat_total", 64'(bp.stat_total), 64'd0);
        chk("stat_miss", 64'(bp.stat_miss), 64'd0);
`endif
        @(posedge clk);
        if (rst_v && uv) begin
            if (ut) begin
                m_cnt[midx(upc)] = (m_cnt[midx(upc)] < 3) ? m_cnt[midx(upc)] + 1 : 3;
                m_val[midx(upc)] = 1'b1;
                m_tag[midx(upc)] = upc / 256;
                m_tgt[midx(upc)] = utg;
            end else begin
                m_cnt[midx(upc)] = (m_cnt[midx(upc)] > 0) ? m_cnt[midx(upc)] - 1 : 0;
            end
            if (m_total < 64'hFFFF_FFFF) m_total++;
            if (mis && m_miss < 64'hFFFF_FFFF) m_miss++;
        end
    endtask

    // Lookup-only cycle with an explicit expectation taken straight from the scenario.
    task automatic probe(input string tag, input logic [31:0] pcf, input bit exp_t, input logic [31:0] exp_tg);
        cycle(1'b1, pcf, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        bp.pc_f = pcf;
        #1;
        chk({tag, "_taken"}, 64'(bp.pred_taken), 64'(exp_t));
        chk({tag, "_target"}, 64'(bp.pred_target), 64'(exp_tg));
    endtask

    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_0110;

    initial begin
        logic [31:0] pcf, upc, utg, uptg;
        bit          ut;
        model_reset();
        bp.pc_f = PA; bp.upd_valid = 1'b0; bp.upd_pc = '0; bp.upd_taken = 1'b0;
        bp.upd_target = '0; bp.upd_pred_taken = 1'b0; bp.upd_pred_target = '0;

        // Reset state; an update presented under reset must flag mispredict but not train.
        cycle(1'b0, PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b0, PA + 4);
        chk("rst_pred_taken", 64'(bp.pred_taken), 64'd0);
        chk("rst_pred_target", 64'(bp.pred_target), 64'h0040_0014);

        // Train PA taken twice.
        cycle(1'b1, PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b0, PA + 4);
        cycle(1'b1, PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b0, PA + 4);
        probe("trained", PA, 1'b1, 32'h0040_0100);

        // Saturation: counter is 3 after 5 more taken; one not-taken keeps taken, second flips.
        for (int i = 0; i < 5; i++) cycle(1'b1, PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
        cycle(1'b1, PA, 1'b1, PA, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
        probe("sat_1nt", PA, 1'b1, 32'h0040_0100);
        cycle(1'b1, PA, 1'b1, PA, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
        probe("sat_2nt", PA, 1'b0, PA + 4);

        // Alias at the same index evicts PA's BTB entry.
        cycle(1'b1, PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b0, PA + 4);
        cycle(1'b1, PB, 1'b1, PB, 1'b1, 32'h0040_0200, 1'b0, PB + 4);
        probe("alias_a", PA, 1'b0, PA + 4);
        probe("alias_b", PB, 1'b1, 32'h0040_0200);

        // Same-edge lookup/update: counter 3 -> taken now; two not-taken drop to 1 -> not-taken next.
        cycle(1'b1, PB, 1'b1, PB, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
        chk("same_edge_old", 64'(m_pred_taken(PB)), 64'd1);
        cycle(1'b1, PB, 1'b1, PB, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
        probe("same_edge_new", PB, 1'b0, PB + 4);

        // Mid-stream async reset drops history at once.
        cycle(1'b1, PB, 1'b1, PB, 1'b1, 32'h0040_0200, 1'b0, PB + 4);
        @(negedge clk);
        bp.upd_valid = 1'b0;
        bp.pc_f = PB;
        #1;
        chk("pre_rst_taken", 64'(bp.pred_taken), 64'd1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_taken", 64'(bp.pred_taken), 64'd0);
        chk("mid_rst_stat_total", 64'(bp.stat_total), 64'd0);
        cycle(1'b0, PB, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Three resolves, one mispredicted.
        cycle(1'b1, PA, 1'b1, PA, 1'b0, 32'h0, 1'b0, PA + 4);
        cycle(1'b1, PA, 1'b1, PA, 1'b1, 32'h0040_0100, 1'b0, PA + 4);
        cycle(1'b1, PA, 1'b1, PB, 1'b0, 32'h0, 1'b0, PB + 4);
        @(negedge clk);
        bp.upd_valid = 1'b0;
        #1;
`ifdef BRANCH_STATS_EN
        chk("stats_total_3", 64'(bp.stat_total), 64'd3);
        chk("stats_miss_1", 64'(bp.stat_miss), 64'd1);
`else
        chk("stats_total_off", 64'(bp.stat_total), 64'd0);
        chk("stats_miss_off", 64'(bp.stat_miss), 64'd0);
`endif

        // Random traffic over a small PC pool so hits, aliases and saturation all recur.
        for (int n = 0; n < 400; n++) begin
            pcf = 32'h0040_0000 + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 2) << 8) + 32'($urandom_range(0, 1));
            upc = 32'h0040_0000 + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 2) << 8);
            ut  = $urandom_range(0, 1) == 1;
            utg = 32'h0050_0000 + ($urandom_range(0, 3) << 4);
            case ($urandom_range(0, 2))
                0:       uptg = m_pred_target(upc);
                1:       uptg = upc + 32'd4;
                default: uptg = utg;
            endcase
            cycle($urandom_range(0, 39) != 0, pcf, $urandom_range(0, 3) != 0, upc, ut, utg,
                  $urandom_range(0, 1) == 1, uptg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
